mram_burst_sequencer: RTL

- Schedules multi-word MRAM read/write bursts onto the serial MRAM access path by driving the 3-bit operation select one 23-cycle slot at a time.
- Serialises the 20-bit address and 16-bit write data MSB-first, aligned to the slot counter.
- Deserialises returned read data and auto-increments the address per word.
- Sits between the host command interface and the MRAM control/shift-register datapath; it is the only owner of the operation select.

---
 rtl/mram_burst_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mram_burst_sequencer.sv
// Burst sequencer for the serial MRAM access path: one word per 23-cycle slot,
// MSB-first address/write-data serialisation and read-word deserialisation.
module mram_burst_sequencer #(
  parameter int SLOT_LEN = 23,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [1:0]        i_cmd_size,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_wr_data_req,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [2:0]        o_rw_sel,
  output logic              o_ser_addr,
  output logic              o_ser_data,
  input  logic              i_ser_rd_in,
  output logic [4:0]        o_slot_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cmd_err
);

  localparam int HALF = DATA_W / 2;
  localparam logic [4:0] C_LAST     = 5'(SLOT_LEN - 1);
  localparam logic [4:0] C_ADDR_END = 5'(ADDR_W);
  localparam logic [4:0] C_DATA_END = 5'(DATA_W);
  localparam logic [4:0] C_FULL_END = 5'(DATA_W + 2);
  localparam logic [4:0] C_HALF_END = 5'(HALF + 2);
  localparam logic [LEN_W:0] C_ONE  = (LEN_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_XFER, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [4:0]        r_slot;
  logic              r_write;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr, r_ash;
  logic [LEN_W:0]    r_rem;
  logic [DATA_W-1:0] r_wsh, r_rd_data;
  logic [DATA_W-2:0] r_rsh;
  logic              r_rd_pend;
  logic [2:0]        r_rw_sel;
  logic              r_ser_addr, r_ser_data, r_wr_data_req, r_rd_valid, r_done, r_cmd_err;

  logic              w_slot_end, w_smp;
  logic [4:0]        w_last_smp;
  logic [HALF-1:0]   w_byte;
  logic [DATA_W-1:0] w_rd_word;
  logic [LEN_W:0]    w_len_ext;

  assign w_slot_end = (r_slot == C_LAST);
  assign w_last_smp = (r_size == 2'b11) ? C_FULL_END : C_HALF_END;
  assign w_smp      = r_rd_pend && (r_slot >= 5'd3) && (r_slot <= w_last_smp);
  assign w_byte     = {r_rsh[HALF-2:0], i_ser_rd_in};
  assign w_len_ext  = (i_cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, i_cmd_len};

  always_comb begin
    w_rd_word = '0;
    case (r_size)
      2'b11:   w_rd_word = {r_rsh, i_ser_rd_in};
      2'b10:   w_rd_word = {w_byte, {HALF{1'b0}}};
      default: w_rd_word = {{HALF{1'b0}}, w_byte};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_slot        <= '0;
      r_write       <= 1'b0;
      r_size        <= '0;
      r_addr        <= '0;
      r_ash         <= '0;
      r_rem         <= '0;
      r_wsh         <= '0;
      r_rsh         <= '0;
      r_rd_data     <= '0;
      r_rd_pend     <= 1'b0;
      r_rw_sel      <= '0;
      r_ser_addr    <= 1'b0;
      r_ser_data    <= 1'b0;
      r_wr_data_req <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_done        <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_slot        <= w_slot_end ? '0 : r_slot + 5'd1;
      r_wr_data_req <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_done        <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_ser_addr    <= 1'b0;
      r_ser_data    <= 1'b0;

      // Shifters are loaded on the edge leaving cycle 1 so bit MSB appears in cycle 2.
      if (r_state == S_XFER) begin
        if (r_slot == 5'd1) begin
          r_ser_addr <= r_addr[ADDR_W-1];
          r_ash      <= r_addr << 1;
          if (r_write) begin
            r_ser_data <= i_wr_data[DATA_W-1];
            r_wsh      <= i_wr_data << 1;
          end
        end else if (r_slot >= 5'd2 && r_slot <= C_ADDR_END) begin
          r_ser_addr <= r_ash[ADDR_W-1];
          r_ash      <= r_ash << 1;
          if (r_write && r_slot <= C_DATA_END) begin
            r_ser_data <= r_wsh[DATA_W-1];
            r_wsh      <= r_wsh << 1;
          end
        end
      end

      if (w_smp) begin
        r_rsh <= {r_rsh[DATA_W-3:0], i_ser_rd_in};
        if (r_slot == w_last_smp) begin
          r_rd_data  <= w_rd_word;
          r_rd_valid <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_size == 2'b00) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_write <= i_cmd_write;
              r_size  <= i_cmd_size;
              r_addr  <= i_cmd_addr;
              r_rem   <= w_len_ext;
              r_state <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (w_slot_end) begin
            r_state       <= S_XFER;
            r_rw_sel      <= {r_size, r_write};
            r_wr_data_req <= r_write;
          end
        end
        S_XFER: begin
          if (w_slot_end) begin
            r_addr    <= r_addr + 1'b1;
            r_rd_pend <= !r_write;
            if (r_rem == C_ONE) begin
              r_rw_sel <= '0;
              r_state  <= r_write ? S_DONE : S_DRAIN;
              r_done   <= r_write;
            end else begin
              r_rem         <= r_rem - 1'b1;
              r_wr_data_req <= r_write;
            end
          end
        end
        S_DRAIN: begin
          if (w_slot_end) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_rd_pend <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_cmd_ready   = !o_busy;
  assign o_slot_cnt    = r_slot;
  assign o_rw_sel      = r_rw_sel;
  assign o_ser_addr    = r_ser_addr;
  assign o_ser_data    = r_ser_data;
  assign o_wr_data_req = r_wr_data_req;
  assign o_rd_data     = r_rd_data;
  assign o_rd_valid    = r_rd_valid;
  assign o_done        = r_done;
  assign o_cmd_err     = r_cmd_err;

endmodule
